// File: rtl/drive_resolve_delay.sv
// -----------------------------------------------------------------------------
// drive_resolve_delay
//
// Multi-channel, cycle-based model of a two-driver net followed by a
// programmable path delay. Each channel resolves driver A and driver B to a
// 4-state value (0/1/X/Z) and passes it through a transport or inertial delay
// stage. Driver contention is flagged per channel and counted globally.
//
// Ports:
//   clk           rising-edge system clock
//   rst           synchronous reset, active-high
//   a_en, a_val   driver A enable / value per channel
//   b_en, b_val   driver B enable / value per channel
//   dly_sel       requested delay in cycles (clamped to MAX_DLY)
//   dly_load      pulse: adopt dly_sel and flush the delay path to X
//   conflict_clr  pulse: clear sticky contention flags and counter
//   o_driven      1 = net driven (0/1/X), 0 = Z
//   o_known       1 = value is 0/1, 0 = X or Z
//   o_val         logic value, forced to 0 whenever o_known = 0
//   conflict      sticky per-channel contention flag (not delayed)
//   conflict_cnt  saturating count of edges with any contention
// -----------------------------------------------------------------------------
module drive_resolve_delay #(
    parameter int WIDTH    = 8,
    parameter int MAX_DLY  = 4,
    parameter int INERTIAL = 0,
    parameter int CNT_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               a_en,
    input  logic [WIDTH-1:0]               a_val,
    input  logic [WIDTH-1:0]               b_en,
    input  logic [WIDTH-1:0]               b_val,
    input  logic [$clog2(MAX_DLY+1)-1:0]   dly_sel,
    input  logic                           dly_load,
    input  logic                           conflict_clr,
    output logic [WIDTH-1:0]               o_driven,
    output logic [WIDTH-1:0]               o_known,
    output logic [WIDTH-1:0]               o_val,
    output logic [WIDTH-1:0]               conflict,
    output logic [CNT_W-1:0]               conflict_cnt
);

    localparam int DW = $clog2(MAX_DLY + 1);

    // Compact 4-state code carried through the delay path.
    typedef enum logic [1:0] {
        NV_0 = 2'b00,
        NV_1 = 2'b01,
        NV_X = 2'b10,
        NV_Z = 2'b11
    } net_t;

    net_t             res      [WIDTH];
    net_t             out_code [WIDTH];
    logic [WIDTH-1:0] cont;
    logic [DW-1:0]    d_act;
    logic [DW-1:0]    d_clamped;

    // -------------------------------------------------------------------------
    // Driver resolution
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            // NOTE: every combinational output gets a default first so no path
            // leaves it unassigned, which would otherwise infer a latch.
            res[i]  = NV_Z;
            cont[i] = 1'b0;
            unique case ({a_en[i], b_en[i]})
                2'b10:   res[i] = a_val[i] ? NV_1 : NV_0;
                2'b01:   res[i] = b_val[i] ? NV_1 : NV_0;
                2'b11: begin
                    if (a_val[i] == b_val[i]) begin
                        res[i] = a_val[i] ? NV_1 : NV_0;
                    end else begin
                        res[i]  = NV_X;
                        cont[i] = 1'b1;
                    end
                end
                default: res[i] = NV_Z;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Active delay register
    // -------------------------------------------------------------------------
    assign d_clamped = (dly_sel > DW'(MAX_DLY)) ? DW'(MAX_DLY) : dly_sel;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            d_act <= '0;
        end else if (dly_load) begin
            d_act <= d_clamped;
        end
    end

    // -------------------------------------------------------------------------
    // Delay stage
    // -------------------------------------------------------------------------
    generate
        if (INERTIAL == 0) begin : g_transport
            // line[0] holds the value sampled at the latest edge; line[d] is
            // what the outputs show, giving d+1 register stages of latency.
            net_t line [MAX_DLY+1][WIDTH];

            always_ff @(posedge clk) begin
                // NOTE: this pipeline is reset on purpose: the outputs must read
                // X until real samples have travelled the whole delay.
                if (rst || dly_load) begin
                    for (int j = 0; j <= MAX_DLY; j++) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            line[j][i] <= NV_X;
                        end
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        line[0][i] <= res[i];
                    end
                    for (int j = 1; j <= MAX_DLY; j++) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            line[j][i] <= line[j-1][i];
                        end
                    end
                end
            end

            always_comb begin
                for (int i = 0; i < WIDTH; i++) begin
                    out_code[i] = line[d_act][i];
                end
            end
        end else begin : g_inertial
            localparam int CW = $clog2(MAX_DLY + 2);
            localparam logic [CW-1:0] STAB_MAX = CW'(MAX_DLY + 1);

            // cand is the last sampled value, stab how many consecutive edges
            // it has been seen. The count saturates once past any legal d+1.
            net_t          cand     [WIDTH];
            net_t          hold     [WIDTH];
            logic [CW-1:0] stab     [WIDTH];
            logic [CW-1:0] stab_nxt [WIDTH];

            always_comb begin
                for (int i = 0; i < WIDTH; i++) begin
                    stab_nxt[i] = CW'(1);
                    if (res[i] == cand[i]) begin
                        stab_nxt[i] = (stab[i] == STAB_MAX) ? stab[i] : stab[i] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst || dly_load) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        cand[i] <= NV_X;
                        hold[i] <= NV_X;
                        stab[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        cand[i] <= res[i];
                        stab[i] <= stab_nxt[i];
                        // Seen on d+1 consecutive edges: let it through.
                        if (stab_nxt[i] > CW'(d_act)) begin
                            hold[i] <= res[i];
                        end
                    end
                end
            end

            always_comb begin
                for (int i = 0; i < WIDTH; i++) begin
                    out_code[i] = hold[i];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            o_driven[i] = (out_code[i] != NV_Z);
            o_known[i]  = (out_code[i] == NV_0) || (out_code[i] == NV_1);
            o_val[i]    = (out_code[i] == NV_1);
        end
    end

    // -------------------------------------------------------------------------
    // Contention reporting (undelayed)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict     <= '0;
            conflict_cnt <= '0;
        end else if (conflict_clr) begin
            // A contention on the clearing edge still registers.
            conflict     <= cont;
            conflict_cnt <= {{(CNT_W-1){1'b0}}, |cont};
        end else begin
            conflict <= conflict | cont;
            if ((|cont) && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drive_resolve_delay.sv
// -----------------------------------------------------------------------------
// tb_drive_resolve_delay
//
// Drives a transport instance (CNT_W=8) and an inertial instance (CNT_W=2)
// with the same stimulus. A history-based reference model predicts every
// output per edge into a scoreboard queue; a monitor pops and compares one
// entry per edge. Scenario tasks add directed checks with fixed expectations.
// -----------------------------------------------------------------------------
module tb_drive_resolve_delay;

    localparam int W  = 8;
    localparam int MD = 4;
    localparam int DW = $clog2(MD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a_en, a_val, b_en, b_val;
    logic [DW-1:0] dly_sel;
    logic          dly_load, conflict_clr;

    logic [W-1:0]  drv_tr, kn_tr, val_tr, conf_tr;
    logic [7:0]    cnt_tr;
    logic [W-1:0]  drv_in, kn_in, val_in, conf_in;
    logic [1:0]    cnt_in;

    always #5 clk = ~clk;

    drive_resolve_delay #(.WIDTH(W), .MAX_DLY(MD), .INERTIAL(0), .CNT_W(8)) u_tr (
        .clk(clk), .rst(rst), .a_en(a_en), .a_val(a_val), .b_en(b_en), .b_val(b_val),
        .dly_sel(dly_sel), .dly_load(dly_load), .conflict_clr(conflict_clr),
        .o_driven(drv_tr), .o_known(kn_tr), .o_val(val_tr),
        .conflict(conf_tr), .conflict_cnt(cnt_tr)
    );

    drive_resolve_delay #(.WIDTH(W), .MAX_DLY(MD), .INERTIAL(1), .CNT_W(2)) u_in (
        .clk(clk), .rst(rst), .a_en(a_en), .a_val(a_val), .b_en(b_en), .b_val(b_val),
        .dly_sel(dly_sel), .dly_load(dly_load), .conflict_clr(conflict_clr),
        .o_driven(drv_in), .o_known(kn_in), .o_val(val_in),
        .conflict(conf_in), .conflict_cnt(cnt_in)
    );

    typedef struct packed {
        logic [W-1:0] drv;
        logic [W-1:0] kn;
        logic [W-1:0] val;
    } vec_t;

    typedef struct packed {
        vec_t         tr;
        vec_t         in;
        logic [W-1:0] conf;
        logic [7:0]   cnt_tr;
        logic [1:0]   cnt_in;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_no = 0;

    // Reference model state
    vec_t         hist[$];
    vec_t         in_out;
    int           d_m = 0;
    logic [W-1:0] conf_m = '0;
    int           cnt_tr_m = 0;
    int           cnt_in_m = 0;

    function automatic vec_t x_vec();
        vec_t v;
        v.drv = '1;
        v.kn  = '0;
        v.val = '0;
        return v;
    endfunction

    function automatic vec_t resolve_now();
        vec_t v;
        for (int i = 0; i < W; i++) begin
            v.drv[i] = a_en[i] | b_en[i];
            v.kn[i]  = 1'b0;
            v.val[i] = 1'b0;
            if (a_en[i] && !b_en[i]) begin
                v.kn[i] = 1'b1; v.val[i] = a_val[i];
            end else if (b_en[i] && !a_en[i]) begin
                v.kn[i] = 1'b1; v.val[i] = b_val[i];
            end else if (a_en[i] && b_en[i] && (a_val[i] == b_val[i])) begin
                v.kn[i] = 1'b1; v.val[i] = a_val[i];
            end
        end
        return v;
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge(output exp_t e);
        vec_t         r;
        vec_t         t;
        logic [W-1:0] c;
        int           n;
        bit           same;
        r = resolve_now();
        c = a_en & b_en & (a_val ^ b_val);
        if (rst) begin
            hist.delete();
            in_out   = x_vec();
            d_m      = 0;
            conf_m   = '0;
            cnt_tr_m = 0;
            cnt_in_m = 0;
            t        = x_vec();
        end else begin
            if (conflict_clr) begin
                conf_m   = c;
                cnt_tr_m = (c != 0) ? 1 : 0;
                cnt_in_m = cnt_tr_m;
            end else begin
                conf_m = conf_m | c;
                if (c != 0) begin
                    if (cnt_tr_m < 255) cnt_tr_m++;
                    if (cnt_in_m < 3)   cnt_in_m++;
                end
            end
            if (dly_load) begin
                d_m = (int'(dly_sel) > MD) ? MD : int'(dly_sel);
                hist.delete();
                in_out = x_vec();
                t      = x_vec();
            end else begin
                hist.push_back(r);
                if (hist.size() > MD + 1) void'(hist.pop_front());
                n = hist.size();
                t = (n > d_m) ? hist[n-1-d_m] : x_vec();
                if (n >= d_m + 1) begin
                    for (int i = 0; i < W; i++) begin
                        same = 1'b1;
                        for (int k = 1; k <= d_m; k++) begin
                            if ({hist[n-1-k].drv[i], hist[n-1-k].kn[i], hist[n-1-k].val[i]} !==
                                {hist[n-1].drv[i], hist[n-1].kn[i], hist[n-1].val[i]})
                                same = 1'b0;
                        end
                        if (same) begin
                            in_out.drv[i] = hist[n-1].drv[i];
                            in_out.kn[i]  = hist[n-1].kn[i];
                            in_out.val[i] = hist[n-1].val[i];
                        end
                    end
                end
            end
        end
        e.tr     = t;
        e.in     = in_out;
        e.conf   = conf_m;
        e.cnt_tr = 8'(cnt_tr_m);
        e.cnt_in = 2'(cnt_in_m);
    endtask

    // One clock edge: predict, enqueue, and return once the monitor has compared.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        edge_no++;
        model_edge(e);
        sb.push_back(e);
        #2;
    endtask

    // Scoreboard monitor
    exp_t m;
    always begin
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            m = sb.pop_front();
            checks += 6;
            if ({drv_tr, kn_tr, val_tr} !== m.tr) begin
                errors++;
                $display("FAIL sb_tr_out edge %0d: got drv=%b kn=%b val=%b, want drv=%b kn=%b val=%b",
                         edge_no, drv_tr, kn_tr, val_tr, m.tr.drv, m.tr.kn, m.tr.val);
            end
            if ({drv_in, kn_in, val_in} !== m.in) begin
                errors++;
                $display("FAIL sb_in_out edge %0d: got drv=%b kn=%b val=%b, want drv=%b kn=%b val=%b",
                         edge_no, drv_in, kn_in, val_in, m.in.drv, m.in.kn, m.in.val);
            end
            if (conf_tr !== m.conf) begin
                errors++;
                $display("FAIL sb_tr_conflict edge %0d: got %b want %b", edge_no, conf_tr, m.conf);
            end
            if (conf_in !== m.conf) begin
                errors++;
                $display("FAIL sb_in_conflict edge %0d: got %b want %b", edge_no, conf_in, m.conf);
            end
            if (cnt_tr !== m.cnt_tr) begin
                errors++;
                $display("FAIL sb_tr_cnt edge %0d: got %0d want %0d", edge_no, cnt_tr, m.cnt_tr);
            end
            if (cnt_in !== m.cnt_in) begin
                errors++;
                $display("FAIL sb_in_cnt edge %0d: got %0d want %0d", edge_no, cnt_in, m.cnt_in);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; a_en = '0; a_val = '0; b_en = '0; b_val = '0;
        dly_sel = '0; dly_load = 1'b0; conflict_clr = 1'b0;
        tick();
        checks++;
        if ({drv_tr, kn_tr, val_tr, conf_tr, cnt_tr} !== {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got drv=%h kn=%h val=%h conf=%h cnt=%0d, want ff 00 00 00 0",
                     drv_tr, kn_tr, val_tr, conf_tr, cnt_tr);
        end
        rst = 1'b0; a_en = '1; a_val = '0;
        tick();
        checks++;
        if ({drv_tr, kn_tr, val_tr} !== {8'hFF, 8'hFF, 8'h00} || {drv_in, kn_in, val_in} !== {8'hFF, 8'hFF, 8'h00}) begin
            errors++;
            $display("FAIL d0_first_edge: got tr kn=%h val=%h in kn=%h val=%h, want ff/00",
                     kn_tr, val_tr, kn_in, val_in);
        end
        a_val = '1;
        tick();
        checks++;
        if (val_tr !== 8'hFF || val_in !== 8'hFF) begin
            errors++;
            $display("FAIL d0_all_ones: got tr=%h in=%h want ff", val_tr, val_in);
        end
    endtask

    task automatic test_transport();
        dly_sel = 3'd3; dly_load = 1'b1;
        tick();
        dly_load = 1'b0; a_val = '0;
        repeat (5) tick();
        a_val = '1;
        tick();
        tick();
        tick();
        checks++;
        if (val_tr[0] !== 1'b0) begin
            errors++;
            $display("FAIL tr_rise_early: got %b want 0", val_tr[0]);
        end
        tick();
        checks++;
        if (val_tr[0] !== 1'b1) begin
            errors++;
            $display("FAIL tr_rise_d3: got %b want 1", val_tr[0]);
        end
        repeat (3) tick();
        a_val = '0;
        tick();
        a_val = '1;
        tick();
        tick();
        tick();
        checks++;
        if (val_tr[0] !== 1'b0 || val_in[0] !== 1'b1) begin
            errors++;
            $display("FAIL tr_pulse_visible: got tr=%b in=%b want tr=0 in=1", val_tr[0], val_in[0]);
        end
        tick();
        checks++;
        if (val_tr[0] !== 1'b1) begin
            errors++;
            $display("FAIL tr_pulse_end: got %b want 1", val_tr[0]);
        end
    endtask

    task automatic test_inertial();
        a_val = '1;
        repeat (5) tick();
        a_val = '0;
        repeat (2) tick();
        a_val = '1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (val_in[0] !== 1'b1) begin
                errors++;
                $display("FAIL in_swallow step %0d: got %b want 1", k, val_in[0]);
            end
        end
        a_val = '0;
        repeat (3) tick();
        checks++;
        if (val_in[0] !== 1'b1) begin
            errors++;
            $display("FAIL in_hold_early: got %b want 1", val_in[0]);
        end
        tick();
        checks++;
        if (val_in[0] !== 1'b0) begin
            errors++;
            $display("FAIL in_hold_4th: got %b want 0", val_in[0]);
        end
    endtask

    task automatic test_contention();
        a_en = '1; a_val = '0; b_en = '0; b_val = '0;
        conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        a_val[2] = 1'b1; b_en[2] = 1'b1; b_val[2] = 1'b0;
        repeat (5) tick();
        checks++;
        if (conf_tr !== 8'h04 || cnt_tr !== 8'd5 || cnt_in !== 2'd3) begin
            errors++;
            $display("FAIL contention_5: got conf=%h cnt_tr=%0d cnt_in=%0d want 04 5 3",
                     conf_tr, cnt_tr, cnt_in);
        end
        checks++;
        if (drv_tr[2] !== 1'b1 || kn_tr[2] !== 1'b0 || val_tr[2] !== 1'b0) begin
            errors++;
            $display("FAIL contention_x: got drv=%b kn=%b val=%b want 1 0 0",
                     drv_tr[2], kn_tr[2], val_tr[2]);
        end
        repeat (2) tick();
        conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        checks++;
        if (cnt_tr !== 8'd1 || cnt_in !== 2'd1 || conf_tr[2] !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_contention: got cnt_tr=%0d cnt_in=%0d flag=%b want 1 1 1",
                     cnt_tr, cnt_in, conf_tr[2]);
        end
    endtask

    task automatic test_equal_and_z();
        a_en = '1; a_val = '0; b_en = '0; b_val = '0;
        a_val[0] = 1'b1; b_en[0] = 1'b1; b_val[0] = 1'b1;
        a_en[1] = 1'b0;
        conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        repeat (4) tick();
        checks++;
        if (conf_tr !== 8'h00 || cnt_tr !== 8'd0) begin
            errors++;
            $display("FAIL equal_no_contention: got conf=%h cnt=%0d want 00 0", conf_tr, cnt_tr);
        end
        checks++;
        if ({kn_tr[0], val_tr[0], drv_tr[1], kn_tr[1], val_tr[1]} !== 5'b11000 ||
            {kn_in[0], val_in[0], drv_in[1], kn_in[1], val_in[1]} !== 5'b11000) begin
            errors++;
            $display("FAIL equal_and_z: got tr=%b in=%b want 11000",
                     {kn_tr[0], val_tr[0], drv_tr[1], kn_tr[1], val_tr[1]},
                     {kn_in[0], val_in[0], drv_in[1], kn_in[1], val_in[1]});
        end
    endtask

    task automatic test_dly_reload();
        dly_sel = 3'd1; dly_load = 1'b1;
        tick();
        dly_load = 1'b0;
        checks++;
        if (kn_tr !== 8'h00 || drv_tr !== 8'hFF || kn_in !== 8'h00 || drv_in !== 8'hFF) begin
            errors++;
            $display("FAIL reload_flush: got tr drv=%h kn=%h in drv=%h kn=%h want ff 00",
                     drv_tr, kn_tr, drv_in, kn_in);
        end
        tick();
        checks++;
        if (kn_tr[0] !== 1'b0) begin
            errors++;
            $display("FAIL reload_lat_early: got %b want 0", kn_tr[0]);
        end
        tick();
        checks++;
        if (kn_tr[0] !== 1'b1 || val_tr[0] !== 1'b1 || val_in[0] !== 1'b1) begin
            errors++;
            $display("FAIL reload_lat1: got tr kn=%b val=%b in val=%b want 1 1 1",
                     kn_tr[0], val_tr[0], val_in[0]);
        end
        dly_sel = 3'd7; dly_load = 1'b1;
        tick();
        dly_load = 1'b0;
        repeat (4) tick();
        checks++;
        if (kn_tr[0] !== 1'b0) begin
            errors++;
            $display("FAIL clamp_early: got %b want 0", kn_tr[0]);
        end
        tick();
        checks++;
        if (kn_tr[0] !== 1'b1) begin
            errors++;
            $display("FAIL clamp_d4: got %b want 1", kn_tr[0]);
        end
    endtask

    task automatic test_reset_mid();
        a_en = '1; b_en = '0; a_val = 8'h5A;
        repeat (2) tick();
        rst = 1'b1; dly_load = 1'b1; dly_sel = 3'd2;
        tick();
        rst = 1'b0; dly_load = 1'b0;
        checks++;
        if (kn_tr !== 8'h00 || drv_tr !== 8'hFF || conf_tr !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got drv=%h kn=%h conf=%h want ff 00 00", drv_tr, kn_tr, conf_tr);
        end
        a_val = 8'hA5;
        tick();
        checks++;
        if (kn_tr !== 8'hFF || val_tr !== 8'hA5) begin
            errors++;
            $display("FAIL reset_mid_d0: got kn=%h val=%h want ff a5", kn_tr, val_tr);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            a_en         = W'($urandom);
            a_val        = W'($urandom);
            b_en         = W'($urandom);
            b_val        = W'($urandom);
            // Hold values for a few edges so inertial updates occur.
            if ($urandom_range(0, 3) != 0) begin
                a_en = '1; b_en = 8'h03;
            end
            dly_sel      = DW'($urandom_range(0, 7));
            dly_load     = ($urandom_range(0, 15) == 0);
            conflict_clr = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 49) == 0);
            repeat ($urandom_range(1, 6)) tick();
        end
        rst = 1'b0; dly_load = 1'b0; conflict_clr = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_transport();
        test_inertial();
        test_contention();
        test_equal_and_z();
        test_dly_reload();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
